// File: rtl/data_scrambler_par_if.sv
// Beat-level valid/ready bus for data_scrambler_par.
// Carries the input stream and the scrambled output stream.
interface data_scrambler_par_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/data_scrambler_par.sv
// 802.11a scrambler/descrambler, S(x) = x^7 + x^4 + 1, DW bits per beat.
// Define SCRAM_SEED_RECOV_EN to enable RX seed recovery from SERVICE zeros.
module data_scrambler_par #(
    parameter int         DW       = 8,
    parameter logic [6:0] SEED_DEF = 7'b1011101
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 scram_load,
    input  logic                 scram_mode,
    input  logic [6:0]           scram_seed,
    data_scrambler_par_if.slave  bus,
    output logic                 seed_lock,
    output logic [6:0]           seed_rec
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef SCRAM_SEED_RECOV_EN
        ST_RECOVER = 2'd1,
`endif
        ST_RUN     = 2'd2
    } state_t;

    state_t          r_state;
    logic [6:0]      r_lfsr;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;

    logic            w_accept;
    logic [6:0]      w_seed_ld;
    logic [6:0]      w_lfsr_nxt;
    logic [DW-1:0]   w_dout;
    logic            w_fb;

`ifdef SCRAM_SEED_RECOV_EN
    logic [2:0]      r_rec_cnt;
    logic            r_seed_lock;
    logic [6:0]      r_seed_rec;
    logic [2:0]      w_rec_cnt;
    logic            w_lock_now;
    logic [6:0]      w_lock_state;
    logic            w_recover;

    assign w_recover = (r_state == ST_RECOVER);
    assign seed_lock = r_seed_lock;
    assign seed_rec  = r_seed_rec;
`else
    logic            w_unused;

    // Without recovery both modes start from the port seed.
    assign w_unused  = scram_mode;
    assign seed_lock = 1'b0;
    assign seed_rec  = 7'd0;
`endif

    assign w_seed_ld    = (scram_seed == 7'd0) ? SEED_DEF : scram_seed;
    assign bus.in_ready = (r_state != ST_IDLE) && !scram_load &&
                          (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

    // Unroll the serial LFSR over one beat, bit 0 first.
    always_comb begin
        w_lfsr_nxt   = r_lfsr;
        w_dout       = '0;
        w_fb         = 1'b0;
`ifdef SCRAM_SEED_RECOV_EN
        w_rec_cnt    = r_rec_cnt;
        w_lock_now   = 1'b0;
        w_lock_state = r_seed_rec;
`endif
        for (int i = 0; i < DW; i++) begin
`ifdef SCRAM_SEED_RECOV_EN
            if (w_recover && (w_rec_cnt != 3'd0)) begin
                w_lfsr_nxt = {w_lfsr_nxt[5:0], bus.in_data[i]};
                w_rec_cnt  = w_rec_cnt - 3'd1;
                if (w_rec_cnt == 3'd0) begin
                    w_lock_now   = 1'b1;
                    w_lock_state = w_lfsr_nxt;
                end
            end else begin
                w_fb       = w_lfsr_nxt[6] ^ w_lfsr_nxt[3];
                w_dout[i]  = bus.in_data[i] ^ w_fb;
                w_lfsr_nxt = {w_lfsr_nxt[5:0], w_fb};
            end
`else
            w_fb       = w_lfsr_nxt[6] ^ w_lfsr_nxt[3];
            w_dout[i]  = bus.in_data[i] ^ w_fb;
            w_lfsr_nxt = {w_lfsr_nxt[5:0], w_fb};
`endif
        end
    end

    // Frame FSM, LFSR state and the registered output beat.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
`ifdef SCRAM_SEED_RECOV_EN
            r_rec_cnt   <= 3'd0;
            r_seed_lock <= 1'b0;
            r_seed_rec  <= 7'd0;
`endif
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_dout;
                r_out_last  <= bus.in_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (scram_load) begin
`ifdef SCRAM_SEED_RECOV_EN
                r_seed_lock <= 1'b0;
                if (scram_mode) begin
                    r_rec_cnt <= 3'd7;
                    r_state   <= ST_RECOVER;
                end else begin
                    r_lfsr    <= w_seed_ld;
                    r_state   <= ST_RUN;
                end
`else
                r_lfsr  <= w_seed_ld;
                r_state <= ST_RUN;
`endif
            end else if (w_accept) begin
                r_lfsr <= w_lfsr_nxt;
`ifdef SCRAM_SEED_RECOV_EN
                r_rec_cnt <= w_rec_cnt;
                if (w_lock_now) begin
                    r_seed_rec  <= w_lock_state;
                    r_seed_lock <= 1'b1;
                end
`endif
                if (bus.in_last) begin
                    r_state <= ST_IDLE;
`ifdef SCRAM_SEED_RECOV_EN
                end else if (w_lock_now) begin
                    r_state <= ST_RUN;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_data_scrambler_par.sv
// Randomized bench for data_scrambler_par (DW=8 and DW=3 instances).
// Reference keystream built from the x^7+x^4+1 recurrence on a bit array.
module tb_data_scrambler_par;

    localparam logic [6:0] SEED_DEF = 7'b1011101;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       ld8  = 1'b0;
    logic       ld3  = 1'b0;
    logic       md   = 1'b0;
    logic [6:0] sd   = 7'd0;
    logic       lock8, lock3;
    logic [6:0] rec8, rec3;

    int   n_vec  = 0;
    int   n_err  = 0;
    bit   got8[$];
    bit   got3[$];
    int   nlast8 = 0;
    int   nlast3 = 0;
    logic [7:0] lk[$];
    bit   rr = 1'b0;

    always #5 clk = ~clk;

    data_scrambler_par_if #(.DW(8)) b8 ();
    data_scrambler_par_if #(.DW(3)) b3 ();

    data_scrambler_par #(.DW(8), .SEED_DEF(SEED_DEF)) u8 (
        .sys_clk(clk), .sys_rstn(rstn), .scram_load(ld8),
        .scram_mode(md), .scram_seed(sd), .bus(b8),
        .seed_lock(lock8), .seed_rec(rec8)
    );

    data_scrambler_par #(.DW(3), .SEED_DEF(SEED_DEF)) u3 (
        .sys_clk(clk), .sys_rstn(rstn), .scram_load(ld3),
        .scram_mode(md), .scram_seed(sd), .bus(b3),
        .seed_lock(lock3), .seed_rec(rec3)
    );

    // Collect every delivered output bit, away from the clock edge.
    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            for (int i = 0; i < 8; i++) got8.push_back(b8.out_data[i]);
            if (b8.out_last) nlast8++;
        end
        if (b3.out_valid && b3.out_ready) begin
            for (int i = 0; i < 3; i++) got3.push_back(b3.out_data[i]);
            if (b3.out_last) nlast3++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keystream x[n] = x[n-7] ^ x[n-4]; RX recovery takes x[0..6] from the line.
    function automatic void model(input logic mode, input logic [6:0] seed,
                                  input bit din[$], output bit dout[$],
                                  output logic [6:0] srec, output int lockbit);
        bit x[$];
        logic [6:0] s0;
        dout    = {};
        srec    = 7'd0;
        lockbit = -1;
        s0      = (seed == 7'd0) ? SEED_DEF : seed;
`ifdef SCRAM_SEED_RECOV_EN
        if (mode) begin
            for (int n = 0; n < din.size(); n++) begin
                if (n < 7) begin
                    x.push_back(din[n]);
                    dout.push_back(1'b0);
                end else begin
                    x.push_back(x[n-7] ^ x[n-4]);
                    dout.push_back(din[n] ^ x[n]);
                end
            end
            if (din.size() >= 7) begin
                lockbit = 6;
                for (int j = 0; j < 7; j++) srec[6-j] = x[j];
            end
            return;
        end
`endif
        for (int j = 0; j < 7; j++) x.push_back(s0[6-j]);
        for (int n = 0; n < din.size(); n++) begin
            x.push_back(x[n] ^ x[n+3]);
            dout.push_back(din[n] ^ x[n+7]);
        end
    endfunction

    function automatic void mk(input int nz, input int nr, output bit q[$]);
        q = {};
        repeat (nz) q.push_back(1'b0);
        repeat (nr) q.push_back(($urandom() % 2) == 1);
    endfunction

    function automatic logic [15:0] pack(input bit q[$], input int b,
                                         input int w);
        logic [15:0] v = '0;
        for (int i = 0; i < w; i++)
            if (b * w + i < q.size()) v[i] = q[b*w+i];
        return v;
    endfunction

    function automatic logic in_rdy(input int sel);
        return (sel != 0) ? b3.in_ready : b8.in_ready;
    endfunction

    task automatic set_rdy(input int sel, input logic v);
        if (sel != 0) b3.out_ready = v;
        else          b8.out_ready = v;
    endtask

    task automatic step(input int sel);
        @(posedge clk);
        #1;
        if (rr) set_rdy(sel, $urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input int sel, input logic v, input logic [15:0] d,
                         input logic l);
        if (sel != 0) begin
            b3.in_valid = v; b3.in_data = d[2:0]; b3.in_last = l;
        end else begin
            b8.in_valid = v; b8.in_data = d[7:0]; b8.in_last = l;
        end
    endtask

    task automatic send(input int sel, input logic [15:0] d, input logic l);
        logic acc = 1'b0;
        int   t   = 0;
        drive(sel, 1'b1, d, l);
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_rdy(sel);
            step(sel);
            t++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        lk.push_back((sel != 0) ? {lock3, rec3} : {lock8, rec8});
    endtask

    task automatic do_load(input int sel, input logic m, input logic [6:0] s);
        md = m;
        sd = s;
        if (sel != 0) ld3 = 1'b1;
        else          ld8 = 1'b1;
        @(negedge clk);
        chk("load_inrdy", {31'd0, in_rdy(sel)}, 0);
        @(posedge clk);
        #1;
        ld3 = 1'b0;
        ld8 = 1'b0;
    endtask

    task automatic drain(input int sel, input int l0);
        int t = 0;
        drive(sel, 1'b0, 16'd0, 1'b0);
        while ((((sel != 0) ? nlast3 : nlast8) == l0) && t < 200) begin
            step(sel);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 0, 1);
        set_rdy(sel, 1'b1);
    endtask

    task automatic run_frame(input int sel, input logic m,
                             input logic [6:0] s, input bit din[$],
                             output bit dout[$]);
        int w  = (sel != 0) ? 3 : 8;
        int nb = din.size() / w;
        int g0 = (sel != 0) ? got3.size() : got8.size();
        int l0 = (sel != 0) ? nlast3 : nlast8;
        lk.delete();
        do_load(sel, m, s);
        for (int b = 0; b < nb; b++) send(sel, pack(din, b, w), b == nb - 1);
        drain(sel, l0);
        if (sel != 0) dout = got3[g0:$];
        else          dout = got8[g0:$];
    endtask

    task automatic cmp_bits(input string tag, input bit got[$],
                            input bit exp[$], input int w);
        chk({tag, "_len"}, got.size(), exp.size());
        if (got.size() == exp.size())
            for (int b = 0; b < exp.size() / w; b++)
                chk(tag, pack(got, b, w), pack(exp, b, w));
    endtask

    task automatic lock_chk(input string tag, input int lb,
                            input logic [6:0] srec, input int w);
        for (int b = 0; b < lk.size(); b++)
            chk({tag, "_lock"}, lk[b][7], (lb >= 0) && (b >= lb / w));
        if (lb >= 0 && lb / w < lk.size())
            chk({tag, "_srec"}, lk[lb/w][6:0], srec);
        else if (lb < 0 && lk.size() > 0)
            chk({tag, "_srec"}, lk[lk.size()-1][6:0], 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit tx[$], sc[$], rc[$], ex[$], o1[$], o2[$], nd[$];
        logic [6:0]  srec, rxs;
        logic [15:0] eb;
        int lb, g0, l0;

        drive(0, 1'b0, 16'd0, 1'b0);
        drive(1, 1'b0, 16'd0, 1'b0);
        b8.out_ready = 1'b1;
        b3.out_ready = 1'b1;
`ifdef SCRAM_SEED_RECOV_EN
        rxs = 7'h11;
`else
        rxs = 7'h5D;
`endif

        #23;
        chk("rst_valid", b8.out_valid, 0);
        chk("rst_data",  b8.out_data, 0);
        chk("rst_last",  b8.out_last, 0);
        chk("rst_lock",  lock8, 0);
        chk("rst_rec",   rec8, 0);
        chk("rst_inrdy", b8.in_ready, 0);
        chk("rst_valid3", b3.out_valid, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        l0 = nlast8;
        do_load(0, 1'b0, 7'h7F);
        send(0, 16'h0, 1'b0);
        chk("tx7f_v0", b8.out_valid, 1);
        chk("tx7f_b0", b8.out_data, 8'h70);
        send(0, 16'h0, 1'b1);
        chk("tx7f_b1", b8.out_data, 8'h4F);
        chk("tx7f_last", b8.out_last, 1);
        drain(0, l0);

        rr = 1'b1;
        mk(0, 40, tx);
        run_frame(0, 1'b0, 7'h00, tx, o1);
        run_frame(0, 1'b0, SEED_DEF, tx, o2);
        cmp_bits("seed0_eq_def", o1, o2, 8);
        model(1'b0, 7'h00, tx, ex, srec, lb);
        cmp_bits("seed0_model", o1, ex, 8);

        mk(16, 64, tx);
        run_frame(0, 1'b0, 7'h5D, tx, sc);
        model(1'b0, 7'h5D, tx, ex, srec, lb);
        cmp_bits("lb8_tx", sc, ex, 8);
        run_frame(0, 1'b1, rxs, sc, rc);
        model(1'b1, rxs, sc, ex, srec, lb);
        cmp_bits("lb8_rx_model", rc, ex, 8);
        cmp_bits("lb8_rx_orig", rc, tx, 8);
        lock_chk("lb8", lb, srec, 8);

        mk(16, 32, tx);
        run_frame(1, 1'b0, 7'h5D, tx, sc);
        model(1'b0, 7'h5D, tx, ex, srec, lb);
        cmp_bits("lb3_tx", sc, ex, 3);
        run_frame(1, 1'b1, rxs, sc, rc);
        model(1'b1, rxs, sc, ex, srec, lb);
        cmp_bits("lb3_rx_model", rc, ex, 3);
        cmp_bits("lb3_rx_orig", rc, tx, 3);
        lock_chk("lb3", lb, srec, 3);

        rr = 1'b0;
        mk(0, 80, tx);
        model(1'b0, 7'h2A, tx, ex, srec, lb);
        g0 = got8.size();
        l0 = nlast8;
        do_load(0, 1'b0, 7'h2A);
        for (int b = 0; b < 3; b++) send(0, pack(tx, b, 8), 1'b0);
        b8.out_ready = 1'b0;
        drive(0, 1'b1, pack(tx, 3, 8), 1'b0);
        eb = pack(ex, 2, 8);
        repeat (5) begin
            @(negedge clk);
            chk("bp_inrdy", b8.in_ready, 0);
            chk("bp_hold", {b8.out_valid, b8.out_last, b8.out_data},
                {1'b1, 1'b0, eb[7:0]});
            @(posedge clk);
            #1;
        end
        b8.out_ready = 1'b1;
        for (int b = 3; b < 10; b++) send(0, pack(tx, b, 8), b == 9);
        drain(0, l0);
        rc = got8[g0:$];
        cmp_bits("bp_frame", rc, ex, 8);

        mk(16, 16, tx);
        run_frame(0, 1'b0, 7'h5D, tx, sc);
        model(1'b1, rxs, sc, ex, srec, lb);
        g0 = got8.size();
        l0 = nlast8;
        lk.delete();
        do_load(0, 1'b1, rxs);
        for (int b = 0; b < 3; b++) send(0, pack(sc, b, 8), 1'b0);
        chk("pre_abort_lock", lk[lk.size()-1][7], lb >= 0);
        b8.out_ready = 1'b0;
        drive(0, 1'b0, 16'd0, 1'b0);
        md  = 1'b0;
        sd  = 7'h4C;
        ld8 = 1'b1;
        @(negedge clk);
        chk("abort_inrdy", b8.in_ready, 0);
        @(posedge clk);
        #1;
        ld8 = 1'b0;
        eb = pack(ex, 2, 8);
        chk("abort_lock", lock8, 0);
        chk("abort_pend", {b8.out_valid, b8.out_data}, {1'b1, eb[7:0]});
        b8.out_ready = 1'b1;
        mk(0, 24, nd);
        for (int b = 0; b < 3; b++) send(0, pack(nd, b, 8), b == 2);
        drain(0, l0);
        rc = got8[g0:$];
        o1 = ex[0:23];
        model(1'b0, 7'h4C, nd, o2, srec, lb);
        o1 = {o1, o2};
        cmp_bits("abort_frame", rc, o1, 8);
        chk("abort_lock_end", lock8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
